// File: rtl/pwm_pkg.sv
// Shared PWM definitions: default counter width, reset divisor
// and the count type reused by the PWM channel comparators.
package pwm_pkg;

    localparam int unsigned PWM_CNT_W       = 8;
    localparam int unsigned PWM_DIV_DEFAULT = 2;

    typedef logic [PWM_CNT_W-1:0] pwm_cnt_t;

endpackage

// File: rtl/pwm_clock_divider_if.sv
// Control/status bundle of the PWM prescaler.
// The controller drives via master; the prescaler uses slave.
interface pwm_clock_divider_if
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W = PWM_CNT_W
);

    logic             enable;
    logic             div_load;
    logic [CNT_W-1:0] div_value;
    logic             div_busy;
    logic [CNT_W-1:0] div_active;
    logic [CNT_W-1:0] phase;
    logic             tick;
    logic             clk_div;

    modport master (
        output enable,
        output div_load,
        output div_value,
        input  div_busy,
        input  div_active,
        input  phase,
        input  tick,
        input  clk_div
    );

    modport slave (
        input  enable,
        input  div_load,
        input  div_value,
        output div_busy,
        output div_active,
        output phase,
        output tick,
        output clk_div
    );

endinterface

// File: rtl/pwm_clock_divider_shadow.sv
// Divisor shadow register: holds a requested terminal count and
// moves it into the active count on a period boundary or when idle.
module div_shadow_reg
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W       = PWM_CNT_W,
    parameter int unsigned DIV_DEFAULT = PWM_DIV_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] value_i,
    input  logic             apply_now_i,
    input  logic             terminal_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] active_o,
    output logic             apply_o
);

    localparam logic [CNT_W-1:0] DefDiv = CNT_W'(DIV_DEFAULT);

    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0] active_q, active_d;
    logic             busy_q, busy_d;

    // A fresh load always wins: the value applies at a boundary after it.
    assign apply_o = busy_q && !load_i && (terminal_i || apply_now_i);

    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        busy_d   = busy_q;
        if (apply_o) begin
            active_d = shadow_q;
            busy_d   = 1'b0;
        end
        if (load_i) begin
            shadow_d = value_i;
            busy_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q <= DefDiv;
            active_q <= DefDiv;
            busy_q   <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            busy_q   <= busy_d;
        end
    end

    assign busy_o   = busy_q;
    assign active_o = active_q;

endmodule

// File: rtl/pwm_clock_divider.sv
// PWM prescaler: phase counter with runtime divisor, registered
// one-cycle tick and 50% divided clock.
module pwm_clock_divider
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W       = PWM_CNT_W,
    parameter int unsigned DIV_DEFAULT = PWM_DIV_DEFAULT
) (
    input logic                clk,
    input logic                reset,
    pwm_clock_divider_if.slave bus
);

    logic [CNT_W-1:0] phase_q, phase_d;
    logic             tick_q, tick_d;
    logic             clk_div_q, clk_div_d;
    logic [CNT_W-1:0] div_active;
    logic             div_busy;
    logic             apply;
    logic             terminal;

    assign terminal = bus.enable && (phase_q == div_active);

    div_shadow_reg #(
        .CNT_W       (CNT_W),
        .DIV_DEFAULT (DIV_DEFAULT)
    ) u_shadow (
        .clk         (clk),
        .reset       (reset),
        .load_i      (bus.div_load),
        .value_i     (bus.div_value),
        .apply_now_i (!bus.enable),
        .terminal_i  (terminal),
        .busy_o      (div_busy),
        .active_o    (div_active),
        .apply_o     (apply)
    );

    always_comb begin
        phase_d   = phase_q;
        tick_d    = 1'b0;
        clk_div_d = clk_div_q;
        if (bus.enable) begin
            phase_d   = terminal ? '0 : phase_q + 1'b1;
            tick_d    = terminal;
            clk_div_d = clk_div_q ^ terminal;
        end else if (apply) begin
            // Idle apply restarts the period phase-aligned.
            phase_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q   <= '0;
            tick_q    <= 1'b0;
            clk_div_q <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            tick_q    <= tick_d;
            clk_div_q <= clk_div_d;
        end
    end

    assign bus.phase      = phase_q;
    assign bus.tick       = tick_q;
    assign bus.clk_div    = clk_div_q;
    assign bus.div_active = div_active;
    assign bus.div_busy   = div_busy;

endmodule

// File: tb/tb_pwm_clock_divider.sv
// Scoreboard bench for pwm_clock_divider against a cycle model
// built from period/pending-divisor arithmetic.
module tb_pwm_clock_divider;

    localparam int CW  = 8;
    localparam int DEF = 2;

    typedef struct {
        int phase;
        int active;
        bit busy;
        bit tick;
        bit clk_div;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    pwm_clock_divider_if #(.CNT_W(CW)) bus ();

    pwm_clock_divider #(
        .CNT_W       (CW),
        .DIV_DEFAULT (DEF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   stim_done = 1'b0;

    int m_phase;
    int m_active;
    int m_periods;
    bit m_tick;
    int m_pend[$];

    // Model one clock edge given the inputs seen at that edge.
    function automatic exp_t model_step(bit rst, bit en, bit ld, int val);
        exp_t e;
        bit   wrap;
        bit   apply;
        if (rst) begin
            m_phase   = 0;
            m_active  = DEF;
            m_periods = 0;
            m_tick    = 0;
            m_pend.delete();
        end else begin
            wrap  = en && (m_phase == m_active);
            apply = (m_pend.size() != 0) && !ld && (wrap || !en);
            m_tick = en && wrap;
            if (en) begin
                if (wrap) m_periods++;
                m_phase = (m_phase + 1) % (m_active + 1);
            end else if (apply) begin
                m_phase = 0;
            end
            if (apply) m_active = m_pend.pop_front();
            if (ld) begin
                m_pend.delete();
                m_pend.push_back(val);
            end
        end
        e.phase   = m_phase;
        e.active  = m_active;
        e.busy    = (m_pend.size() != 0);
        e.tick    = m_tick;
        e.clk_div = m_periods[0];
        return e;
    endfunction

    task automatic cyc(bit rst, bit en, bit ld, int val);
        @(negedge clk);
        reset         = rst;
        bus.enable    = en;
        bus.div_load  = ld;
        bus.div_value = val[CW-1:0];
        exp_q.push_back(model_step(rst, en, ld, val));
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) cyc(0, 1, 0, 0);
    endtask

    // Monitor: compare the post-edge DUT state with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (int'(bus.phase) != e.phase || int'(bus.div_active) != e.active
                    || bus.div_busy != e.busy || bus.tick != e.tick
                    || bus.clk_div != e.clk_div) begin
                    n_bad++;
                    $display("FAIL state t=%0t got ph=%0d act=%0d busy=%0b tick=%0b cd=%0b want ph=%0d act=%0d busy=%0b tick=%0b cd=%0b",
                             $time, bus.phase, bus.div_active, bus.div_busy, bus.tick,
                             bus.clk_div, e.phase, e.active, e.busy, e.tick, e.clk_div);
                end
            end
        end
    end

    initial begin
        int v;
        reset         = 1'b1;
        bus.enable    = 1'b0;
        bus.div_load  = 1'b0;
        bus.div_value = '0;

        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        run(12);

        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 1, 4);
        run(14);

        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 1, 0);
        run(10);

        cyc(1, 0, 0, 0);
        cyc(0, 1, 1, 7);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        run(18);

        cyc(1, 0, 0, 0);
        cyc(0, 1, 1, 5);
        cyc(0, 1, 1, 3);
        run(10);

        cyc(1, 0, 0, 0);
        cyc(0, 1, 1, 6);
        cyc(0, 1, 0, 0);
        cyc(1, 1, 1, 9);
        run(6);

        cyc(0, 0, 1, 3);
        cyc(0, 0, 1, 5);
        cyc(0, 0, 0, 0);
        run(8);

        cyc(0, 0, 1, 255);
        cyc(0, 0, 0, 0);
        run(520);

        cyc(1, 0, 0, 0);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(99) < 20) v = 0;
            else if ($urandom_range(99) < 3) v = 255;
            else v = $urandom_range(9);
            cyc(($urandom_range(299) == 0), ($urandom_range(99) < 85),
                ($urandom_range(14) == 0), v);
        end
        run(4);
        stim_done = 1'b1;
    end

    initial begin
        int guard = 0;
        wait (stim_done);
        while (exp_q.size() != 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        #2;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got no finish want finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

endmodule

// File: doc/pwm_clock_divider.md
Name: pwm_clock_divider

Overview:
Parametrised successor to the fixed divide-by-3 PWM prescaler. It generates a single-cycle clock-enable tick, a toggled divided clock and a phase count for the PWM channel comparators. The divisor is loaded at run time through a shadow register and takes effect glitch-free on a period boundary. It sits between the system clock and the RGBW PWM channels.

Parameters:
CNT_W, 8, width of the counter, divisor and phase.
DIV_DEFAULT, 2, terminal count after reset; 2 reproduces the legacy period of 3 clk cycles per half-period.

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
enable  in  1  1 = count; 0 = freeze counter and outputs
div_load  in  1  1-cycle strobe: capture div_value into the shadow register
div_value  in  CNT_W  requested terminal count (period = value+1 clk cycles)
div_busy  out  1  shadow value pending, not yet applied
div_active  out  CNT_W  terminal count currently in use
phase  out  CNT_W  current counter value, 0..div_active
tick  out  1  registered 1-cycle pulse, once per period
clk_div  out  1  registered; toggles once per period (duty 50%, period 2*(div_active+1))

Behaviour:
- Reset (sampled on clk while reset=1): phase=0, div_active=DIV_DEFAULT, shadow=DIV_DEFAULT, div_busy=0, tick=0, clk_div=0. Reset overrides all other inputs, including mid-period and a pending load; any pending load is discarded.
- Counting with enable=1: phase increments by 1 each cycle. When phase==div_active (terminal cycle T):
  - phase becomes 0 at T+1.
  - tick=1 during T+1 only.
  - clk_div inverts at T+1.
- Latency: tick and clk_div change 1 cycle after the terminal cycle. The first tick after reset release is in cycle div_active+1, counting the first enabled cycle as 0.
- div_value=0: terminal every cycle; tick stays high continuously; clk_div = clk/2.
- Load, capture: div_load=1 captures div_value into shadow and sets div_busy=1 on the next cycle.
  - A second load while busy overwrites shadow (last write wins); div_busy stays 1.
- Load, apply with enable=1: at the first terminal cycle strictly after the capture cycle, div_active<=shadow and div_busy<=0, together with the phase wrap.
  - A load in the terminal cycle itself applies at the following terminal, never the current one.
- Load, apply with enable=0: a pending shadow is applied on the next cycle; phase is cleared to 0 and div_busy<=0. This gives a phase-aligned restart.
- div_load during a pending immediate apply: the new value wins and becomes pending again.
- enable=0: phase, clk_div and div_active hold (except as above); tick=0.
  - enable rising: counting resumes from the held phase, or from 0 after an apply.
- phase never exceeds div_active: changes to div_active occur only when phase wraps to 0 or is cleared.
- Arithmetic: unsigned, CNT_W bits. Wrap is by compare, never by overflow; div_value = 2^CNT_W-1 is legal (period 2^CNT_W).

Decomposition:
- Shared package pwm_pkg:
  - CNT_W and DIV_DEFAULT defaults.
  - A typedef for the CNT_W count vector, reused by the PWM channel comparators.
- Optional sub-module div_shadow_reg: shadow, div_busy, div_active and the apply logic, with inputs load, value, apply_now, terminal.
- The counter and outputs stay in the top module.

Test Plan:
- Reset release, enable=1, default divisor 2 -> phase 0,1,2,0,...; tick high in cycles 3,6,9; clk_div toggles at 3,6,9 (period 6).
- Load div_value=4 at cycle 1 -> div_busy=1 from cycle 2; applied at terminal cycle 2 (div_active=4 at cycle 3, busy=0); next ticks at cycles 8,13.
- Load in the terminal cycle (value 0 at cycle 2) -> the current wrap keeps 2; applied at cycle-5 terminal; thereafter tick continuous and clk_div toggles every cycle.
- enable=0 at phase=1 with div_value=7 loaded -> next cycle div_active=7, phase=0, busy=0, tick=0, clk_div held; enable=1 -> first tick after 8 cycles.
- Two loads (5 then 3) before a terminal -> div_active becomes 3 only; div_busy falls exactly once.
- Assert reset mid-period with a load pending -> all outputs return to reset values next cycle; div_active=2, div_busy=0.
